// File: rtl/cmd_pkg.sv
// Shared definitions for the /CMD writer: record types, FSM states and the optional header record.
// The header record is only emitted when CMD_WRITER_HEADER_EN is defined.
package cmd_pkg;

  localparam logic [7:0] CMD_REC_LOAD = 8'h01;
  localparam logic [7:0] CMD_REC_XFER = 8'h02;
  localparam logic [7:0] CMD_REC_HDR  = 8'h05;

  localparam int          CMD_HDR_LEN = 8;
  localparam logic [63:0] CMD_HDR_STR = 64'h05_06_4D_49_53_54_45_52;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_REC_TYPE,
    ST_REC_LEN,
    ST_REC_ALO,
    ST_REC_AHI,
    ST_DATA,
    ST_XFR_TYPE,
    ST_XFR_LEN,
    ST_XFR_ALO,
    ST_XFR_AHI
  } cmd_wr_state_t;

  // Byte idx of the header record, most significant byte of CMD_HDR_STR first.
  function automatic logic [7:0] cmd_hdr_byte(input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < CMD_HDR_LEN; i++) begin
      if (idx == 3'(i)) b = CMD_HDR_STR[63 - 8*i -: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/cmd_out_stage.sv
// Single-entry output register with valid/ready hold and the end-of-file flag.
// A new byte may be loaded only when the register is empty or being accepted.
module cmd_out_stage (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_last,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       accept
);

  assign accept = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
      out_last  <= load_last;
    end else if (accept) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_writer.sv
// Serialises a RAM range into a /CMD stream: load records, then one transfer record.
// Define CMD_WRITER_HEADER_EN to prepend the "MISTER" header record.
module cmd_writer
  import cmd_pkg::*;
#(
  parameter int BLK_MAX = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  input  logic [15:0] exec_addr,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [16:0] byte_count
);

  cmd_wr_state_t state, state_n;

  // rec_addr is the next unread address; 17 bits so that reading FFFF lands on 10000 and ends the job.
  logic [16:0] rec_addr;
  logic [15:0] end_reg;
  logic [15:0] exec_reg;
  logic [15:0] addr_hold;
  logic [8:0]  blk_left;
  logic [3:0]  hdr_idx;
  logic        cap_pend;

  logic        accept;
  logic        ld;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        rd;

  logic        more;
  logic [16:0] job_left;
  logic [8:0]  blk_sz;

  assign more     = (rec_addr <= {1'b0, end_reg});
  assign job_left = {1'b0, end_reg} - rec_addr + 17'd1;
  assign blk_sz   = (job_left >= 17'(BLK_MAX)) ? 9'(BLK_MAX) : job_left[8:0];

  assign mem_rd   = rd;
  assign mem_addr = rd ? rec_addr[15:0] : addr_hold;
  assign busy     = (state != ST_IDLE);

  cmd_out_stage u_out (
    .clock     (clock),
    .reset     (reset),
    .load      (ld),
    .load_data (ld_data),
    .load_last (ld_last),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .accept    (accept)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // The state names the byte currently held in the output stage; each acceptance loads its successor.
  always_comb begin
    state_n = state;
    ld      = 1'b0;
    ld_data = 8'h00;
    ld_last = 1'b0;
    rd      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          ld = 1'b1;
`ifdef CMD_WRITER_HEADER_EN
          ld_data = CMD_REC_HDR;
          state_n = ST_HDR;
`else
          if (end_addr < start_addr) begin
            ld_data = CMD_REC_XFER;
            state_n = ST_XFR_TYPE;
          end else begin
            ld_data = CMD_REC_LOAD;
            state_n = ST_REC_TYPE;
          end
`endif
        end
      end
      ST_HDR: begin
        if (accept) begin
          ld = 1'b1;
          if (hdr_idx != 4'(CMD_HDR_LEN)) begin
            ld_data = cmd_hdr_byte(hdr_idx[2:0]);
          end else if (more) begin
            ld_data = CMD_REC_LOAD;
            state_n = ST_REC_TYPE;
          end else begin
            ld_data = CMD_REC_XFER;
            state_n = ST_XFR_TYPE;
          end
        end
      end
      ST_REC_TYPE: begin
        if (accept) begin
          ld      = 1'b1;
          ld_data = blk_sz[7:0] + 8'd2;
          state_n = ST_REC_LEN;
        end
      end
      ST_REC_LEN: begin
        if (accept) begin
          ld      = 1'b1;
          ld_data = rec_addr[7:0];
          state_n = ST_REC_ALO;
        end
      end
      ST_REC_ALO: begin
        if (accept) begin
          ld      = 1'b1;
          ld_data = rec_addr[15:8];
          state_n = ST_REC_AHI;
        end
      end
      ST_REC_AHI: begin
        if (accept) begin
          rd      = 1'b1;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        // The read for the next byte is issued as the current one is accepted, so a byte costs two cycles.
        if (cap_pend) begin
          ld      = 1'b1;
          ld_data = mem_din;
        end
        if (accept) begin
          if (blk_left > 9'd1) begin
            rd = 1'b1;
          end else if (more) begin
            ld      = 1'b1;
            ld_data = CMD_REC_LOAD;
            state_n = ST_REC_TYPE;
          end else begin
            ld      = 1'b1;
            ld_data = CMD_REC_XFER;
            state_n = ST_XFR_TYPE;
          end
        end
      end
      ST_XFR_TYPE: begin
        if (accept) begin
          ld      = 1'b1;
          ld_data = CMD_REC_XFER;
          state_n = ST_XFR_LEN;
        end
      end
      ST_XFR_LEN: begin
        if (accept) begin
          ld      = 1'b1;
          ld_data = exec_reg[7:0];
          state_n = ST_XFR_ALO;
        end
      end
      ST_XFR_ALO: begin
        if (accept) begin
          ld      = 1'b1;
          ld_data = exec_reg[15:8];
          ld_last = 1'b1;
          state_n = ST_XFR_AHI;
        end
      end
      ST_XFR_AHI: begin
        if (accept) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rec_addr   <= 17'd0;
      end_reg    <= 16'h0000;
      exec_reg   <= 16'h0000;
      addr_hold  <= 16'h0000;
      blk_left   <= 9'd0;
      hdr_idx    <= 4'd0;
      cap_pend   <= 1'b0;
      done       <= 1'b0;
      byte_count <= 17'd0;
    end else begin
      cap_pend <= rd;
      done     <= accept && (state == ST_XFR_AHI);
      if (state == ST_IDLE && start) begin
        rec_addr   <= {1'b0, start_addr};
        end_reg    <= end_addr;
        exec_reg   <= exec_addr;
        hdr_idx    <= 4'd1;
        byte_count <= 17'd0;
      end else if (accept) begin
        byte_count <= byte_count + 17'd1;
      end
      if (state == ST_HDR && accept && hdr_idx != 4'(CMD_HDR_LEN)) hdr_idx <= hdr_idx + 4'd1;
      if (state == ST_REC_TYPE && accept) blk_left <= blk_sz;
      if (state == ST_DATA && accept) blk_left <= blk_left - 9'd1;
      if (rd) begin
        rec_addr  <= rec_addr + 17'd1;
        addr_hold <= rec_addr[15:0];
      end
    end
  end

endmodule

// File: tb/tb_cmd_writer.sv
// Self-checking bench for cmd_writer: directed ranges, random stalls and a mid-job reset,
// checked against a record-level model of the /CMD format.
module tb_cmd_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] start_addr = 16'h0000;
  logic [15:0] end_addr = 16'h0000;
  logic [15:0] exec_addr = 16'h0000;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [16:0] byte_count;

  cmd_writer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .exec_addr  (exec_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [0:65535];
  always @(posedge clock) if (mem_rd) mem_din <= ram[mem_addr];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  bit stall_mode = 1'b0;

  logic [7:0] got_q [$];
  bit         last_q [$];
  logic [7:0] exp_q [$];
  int         done_cnt, done_cycle, last_cycle, unstable, max_addr;
  bit         prev_hold;
  logic [7:0] prev_data;
  logic       prev_last;

  initial forever begin
    @(posedge clock);
    cycle++;
  end

  initial forever begin
    @(posedge clock);
    #1;
    out_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Observes the stream mid-cycle: accepted bytes, hold stability, done timing, highest read address.
  initial forever begin
    @(negedge clock);
    if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
      unstable++;
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    prev_last = out_last;
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      last_q.push_back(out_last);
      if (out_last) last_cycle = cycle;
    end
    if (done) begin
      done_cnt++;
      done_cycle = cycle;
    end
    if (mem_rd && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic resetMonitor();
    got_q.delete();
    last_q.delete();
    done_cnt   = 0;
    done_cycle = -1;
    last_cycle = -100;
    unstable   = 0;
    max_addr   = -1;
    prev_hold  = 1'b0;
  endtask

  // Reference model: the file as a list of records, built straight from the range arithmetic.
  function automatic void buildExpected(input int s, input int e, input int x);
    int a, rem, n;
    exp_q.delete();
`ifdef CMD_WRITER_HEADER_EN
    exp_q.push_back(8'h05); exp_q.push_back(8'h06); exp_q.push_back(8'h4D); exp_q.push_back(8'h49);
    exp_q.push_back(8'h53); exp_q.push_back(8'h54); exp_q.push_back(8'h45); exp_q.push_back(8'h52);
`endif
    if (e >= s) begin
      a   = s;
      rem = e - s + 1;
      while (rem > 0) begin
        n = (rem > 256) ? 256 : rem;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'((n + 2) % 256));
        exp_q.push_back(8'(a % 256));
        exp_q.push_back(8'(a / 256));
        for (int i = 0; i < n; i++) exp_q.push_back(ram[a + i]);
        a   += n;
        rem -= n;
      end
    end
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'(x % 256));
    exp_q.push_back(8'(x / 256));
  endfunction

  task automatic applyStimulus(input int s, input int e, input int x, input bit stall, input bit wait_done);
    int budget;
    buildExpected(s, e, x);
    resetMonitor();
    stall_mode = stall;
    @(posedge clock);
    #2;
    start_addr = 16'(s);
    end_addr   = 16'(e);
    exec_addr  = 16'(x);
    start      = 1'b1;
    @(posedge clock);
    #2;
    start = 1'b0;
    @(negedge clock);
    checkOutput("first_busy", 32'(busy), 32'd1);
    checkOutput("first_valid", 32'(out_valid), 32'd1);
    checkOutput("first_byte", 32'(out_data), 32'(exp_q[0]));
    if (wait_done) begin
      budget = exp_q.size() * 8 + 200;
      for (int i = 0; i < budget; i++) begin
        @(negedge clock);
        if (done_cnt != 0) break;
      end
      repeat (2) @(negedge clock);
    end
  endtask

  task automatic checkJob(input string tag);
    int mism, ones;
    mism = 0;
    ones = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    foreach (last_q[i]) ones += int'(last_q[i]);
    checkOutput({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    checkOutput({tag, "_bytes_wrong"}, 32'(mism), 32'd0);
    checkOutput({tag, "_last_count"}, 32'(ones), 32'd1);
    checkOutput({tag, "_last_final"}, (last_q.size() > 0) ? 32'(last_q[last_q.size() - 1]) : 32'd0, 32'd1);
    checkOutput({tag, "_byte_count"}, 32'(byte_count), 32'(exp_q.size()));
    checkOutput({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    checkOutput({tag, "_done_delay"}, 32'(done_cycle - last_cycle), 32'd1);
    checkOutput({tag, "_unstable"}, 32'(unstable), 32'd0);
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_last"}, 32'(out_last), 32'd0);
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_byte_count"}, 32'(byte_count), 32'd0);
  endtask

  initial begin
    logic [7:0] lit [11];
    logic [7:0] hdr [8];
    int mism, s, len;
    lit = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h52};
    hdr = '{8'h05, 8'h06, 8'h4D, 8'h49, 8'h53, 8'h54, 8'h45, 8'h52};
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[16'h5200] = 8'hAA;
    ram[16'h5201] = 8'hBB;
    ram[16'h5202] = 8'hCC;
    resetMonitor();

    repeat (3) @(negedge clock);
    checkResetValues("reset");
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("[TB] small job 5200..5202");
    applyStimulus(32'h5200, 32'h5202, 32'h5200, 1'b0, 1'b1);
    checkJob("small");
    mism = 0;
`ifdef CMD_WRITER_HEADER_EN
    for (int i = 0; i < 8; i++) if (i >= got_q.size() || got_q[i] !== hdr[i]) mism++;
    checkOutput("small_header_literal", 32'(mism), 32'd0);
    checkOutput("small_total", 32'(byte_count), 32'd19);
`else
    for (int i = 0; i < 11; i++) if (i >= got_q.size() || got_q[i] !== lit[i]) mism++;
    checkOutput("small_literal", 32'(mism), 32'd0);
    checkOutput("small_total", 32'(byte_count), 32'd11);
`endif

    $display("[TB] two full records 4000..41FF");
    applyStimulus(32'h4000, 32'h41FF, 32'h4000, 1'b0, 1'b1);
    checkJob("two_rec");

    $display("[TB] empty range 3001..3000");
    applyStimulus(32'h3001, 32'h3000, 32'h3000, 1'b0, 1'b1);
    checkJob("empty");

    $display("[TB] top of memory FE01..FFFF");
    applyStimulus(32'hFE01, 32'hFFFF, 32'h1234, 1'b0, 1'b1);
    checkJob("top");
    checkOutput("top_max_addr", 32'(max_addr), 32'hFFFF);

    $display("[TB] 254-byte record");
    applyStimulus(32'h1000, 32'h10FD, 32'h1000, 1'b0, 1'b1);
    checkJob("len00");

    $display("[TB] stalled small job");
    applyStimulus(32'h5200, 32'h5202, 32'h5200, 1'b1, 1'b1);
    checkJob("stall_small");

    for (int j = 0; j < 3; j++) begin
      s   = $urandom_range(0, 60000);
      len = $urandom_range(1, 700);
      $display("[TB] random stalled job %0d start=%0h len=%0d", j, s, len);
      applyStimulus(s, s + len - 1, int'($urandom_range(0, 65535)), 1'b1, 1'b1);
      checkJob($sformatf("rand%0d", j));
    end

    $display("[TB] reset during data phase");
    applyStimulus(32'h6000, 32'h60FF, 32'h6000, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (mem_rd) break;
    end
    repeat (3) @(negedge clock);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock);
    checkResetValues("mid_reset");
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("mid_reset_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(32'h6000, 32'h60FF, 32'h6000, 1'b1, 1'b1);
    checkJob("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
